// File: rtl/stream_rate_limit_pkg.sv
// Shared sizing helpers for the stream rate limiter and its spill buffer.
package stream_rate_limit_pkg;

    function automatic int credit_width(input int max_beats);
        return $clog2(max_beats + 1);
    endfunction

    function automatic int win_width(input int cycles);
        return $clog2(cycles);
    endfunction

endpackage

// File: rtl/stream_spill_buf.sv
// Two-entry registered FIFO with valid/ready on both sides; in_ready_o and the
// flags come straight from the occupancy register.
module stream_spill_buf #(
    parameter type payload_t = logic
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  payload_t in_data_i,
    input  logic     in_valid_i,
    output logic     in_ready_o,
    output payload_t out_data_o,
    output logic     out_valid_o,
    input  logic     out_ready_i,
    output logic     empty_o,
    output logic     full_o
);

    payload_t   mem_q [2];
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] cnt_q, cnt_d;
    logic       push, pop;

    assign full_o      = (cnt_q == 2'd2);
    assign empty_o     = (cnt_q == 2'd0);
    assign in_ready_o  = !full_o;
    assign out_valid_o = !empty_o;
    assign out_data_o  = mem_q[rd_ptr_q];

    assign push = in_valid_i && !full_o;
    assign pop  = out_ready_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;
        cnt_d    = cnt_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data_i;
        end
        if (!rst_i) begin
            assert (!(in_valid_i && in_ready_o && full_o)) else $error("spill_buf: write while full");
            assert (!(out_ready_i && out_valid_o && empty_o)) else $error("spill_buf: read while empty");
        end
    end

endmodule

// File: rtl/stream_rate_limit.sv
// Forwards a valid/ready stream through a 2-entry buffer, allowing at most
// MaxBeats output handshakes per free-running WindowCycles-cycle window.
module stream_rate_limit
    import stream_rate_limit_pkg::*;
#(
    parameter int  MaxBeats     = 4,
    parameter int  WindowCycles = 16,
    parameter type payload_t    = logic
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  payload_t                          payload_i,
    input  logic                              valid_i,
    output logic                              ready_o,
    output payload_t                          payload_o,
    output logic                              valid_o,
    input  logic                              ready_i,
    output logic [credit_width(MaxBeats)-1:0] credits_o,
    output logic                              stall_o
);

    localparam int CW = credit_width(MaxBeats);
    localparam int WW = win_width(WindowCycles);
    localparam logic [CW-1:0] CREDIT_MAX = CW'(MaxBeats);
    localparam logic [WW-1:0] WIN_LAST   = WW'(WindowCycles - 1);

    if (MaxBeats < 1 || MaxBeats > WindowCycles || WindowCycles < 2) begin : g_bad_params
        $error("stream_rate_limit: illegal MaxBeats/WindowCycles combination");
    end

    logic [CW-1:0] credit_q, credit_d;
    logic [WW-1:0] win_q, win_d;
    logic          buf_valid, buf_in_ready, buf_empty, buf_full;
    logic          credit_ok, out_fire, win_last;
    payload_t      buf_data;

    assign credit_ok = (credit_q != '0);
    assign out_fire  = buf_valid && credit_ok && ready_i;
    assign win_last  = (win_q == WIN_LAST);

    stream_spill_buf #(.payload_t(payload_t)) u_buf (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_data_i   (payload_i),
        .in_valid_i  (valid_i),
        .in_ready_o  (buf_in_ready),
        .out_data_o  (buf_data),
        .out_valid_o (buf_valid),
        .out_ready_i (ready_i && credit_ok),
        .empty_o     (buf_empty),
        .full_o      (buf_full)
    );

    // Outputs are forced to their reset values for the whole reset cycle,
    // including the very first one before any clock edge has been seen.
    assign ready_o   = buf_in_ready && !rst_i;
    assign valid_o   = buf_valid && credit_ok && !rst_i;
    assign payload_o = buf_data;
    assign credits_o = rst_i ? CREDIT_MAX : credit_q;
    assign stall_o   = !rst_i && !buf_empty && !credit_ok;

    // Refill takes priority: a handshake in the last window cycle is charged to the old window.
    always_comb begin
        win_d    = win_last ? '0 : win_q + WW'(1);
        credit_d = credit_q;
        if (win_last) begin
            credit_d = CREDIT_MAX;
        end else if (out_fire) begin
            credit_d = credit_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            win_q    <= '0;
            credit_q <= CREDIT_MAX;
        end else begin
            win_q    <= win_d;
            credit_q <= credit_d;
        end
    end

    logic     hold_q;
    payload_t held_pay_q;

    always_ff @(posedge clk_i) begin
        hold_q     <= rst_i ? 1'b0 : (valid_o && !ready_i);
        held_pay_q <= payload_o;
        if (!rst_i) begin
            assert (credit_q <= CREDIT_MAX) else $error("rate_limit: credit out of range");
            assert (!(valid_i && ready_o && buf_full)) else $error("rate_limit: write while full");
            if (hold_q) begin
                assert (valid_o && payload_o == held_pay_q) else $error("rate_limit: output changed under backpressure");
            end
        end
    end

endmodule

// File: tb/tb_stream_rate_limit.sv
// Directed bench for stream_rate_limit: scoreboard queues track payload order,
// directed checks cover credit, window and stall timing at hand-computed cycles.
module tb_stream_rate_limit;

    typedef logic [7:0] pl_t;

    logic       clk = 1'b0;
    logic       rst_i, valid_i, ready_i, ready_o, valid_o, stall_o;
    pl_t        payload_i, payload_o;
    logic [2:0] credits_o;

    logic       rst2, valid2, ready2, ready2_o, valid2_o, stall2_o;
    pl_t        payload2, payload2_o;
    logic [3:0] credits2_o;

    int  n_cmp = 0;
    int  n_err = 0;
    pl_t q1[$];
    pl_t q2[$];

    always #5 clk = ~clk;

    stream_rate_limit #(.MaxBeats(4), .WindowCycles(16), .payload_t(pl_t)) dut (
        .clk_i(clk), .rst_i(rst_i), .payload_i(payload_i), .valid_i(valid_i),
        .ready_o(ready_o), .payload_o(payload_o), .valid_o(valid_o),
        .ready_i(ready_i), .credits_o(credits_o), .stall_o(stall_o)
    );

    stream_rate_limit #(.MaxBeats(8), .WindowCycles(8), .payload_t(pl_t)) dut2 (
        .clk_i(clk), .rst_i(rst2), .payload_i(payload2), .valid_i(valid2),
        .ready_o(ready2_o), .payload_o(payload2_o), .valid_o(valid2_o),
        .ready_i(ready2), .credits_o(credits2_o), .stall_o(stall2_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitors: pop the oldest accepted beat on every output handshake.
    always @(negedge clk) begin
        if (valid_o && ready_i) begin
            if (q1.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL sb1: unexpected beat 0x%0h with nothing outstanding", payload_o);
            end else begin
                pl_t e;
                e = q1.pop_front();
                chk("sb1 payload", 32'(payload_o), 32'(e));
            end
        end
    end

    always @(negedge clk) begin
        if (valid2_o && ready2) begin
            if (q2.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL sb2: unexpected beat 0x%0h with nothing outstanding", payload2_o);
            end else begin
                pl_t e;
                e = q2.pop_front();
                chk("sb2 payload", 32'(payload2_o), 32'(e));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n_in, n_out, stall_seen;
        logic hs_in;

        rst_i = 1'b1; valid_i = 1'b1; ready_i = 1'b0; payload_i = '0;
        rst2 = 1'b1; valid2 = 1'b0; ready2 = 1'b0; payload2 = '0;
        n_in = 0; n_out = 0; stall_seen = 0;

        // Reset held with valid_i asserted.
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk($sformatf("rst ready_o k%0d", k), 32'(ready_o), 0);
            chk($sformatf("rst valid_o k%0d", k), 32'(valid_o), 0);
            chk($sformatf("rst credits k%0d", k), 32'(credits_o), 4);
        end
        @(posedge clk); #1;

        for (int c = 0; c < 90; c++) begin
            rst_i   = (c == 68);
            ready_i = !((c >= 50 && c <= 54) || c == 66 || c == 67);
            valid_i = 1'b0;
            if (n_in < 10) begin
                valid_i = 1'b1; payload_i = pl_t'(n_in);
            end else if (c == 44 || c == 46) begin
                valid_i = 1'b1; payload_i = (c == 44) ? 8'hA0 : 8'hA1;
            end else if (c >= 50 && c <= 54) begin
                valid_i = 1'b1; payload_i = 8'hB0 + pl_t'(n_in - 12);
            end else if (c == 66 || c == 67) begin
                valid_i = 1'b1; payload_i = 8'hC0 + pl_t'(n_in - 14);
            end else if (c == 70) begin
                valid_i = 1'b1; payload_i = 8'hD0;
            end

            @(negedge clk);
            case (c)
                0: begin
                    chk("rel ready_o", 32'(ready_o), 1);
                    chk("rel credits", 32'(credits_o), 4);
                    chk("rel valid_o", 32'(valid_o), 0);
                end
                1: chk("first beat", 32'({valid_o, payload_o}), 32'h100);
                5: begin
                    chk("burst stall", 32'(stall_o), 1);
                    chk("burst valid_o", 32'(valid_o), 0);
                    chk("burst credits", 32'(credits_o), 0);
                    chk("burst count", 32'(n_out), 4);
                end
                6: chk("burst full ready_o", 32'(ready_o), 0);
                15: begin
                    chk("win end valid_o", 32'(valid_o), 0);
                    chk("win end stall", 32'(stall_o), 1);
                    chk("win end count", 32'(n_out), 4);
                end
                16: begin
                    chk("new win beat", 32'({valid_o, payload_o}), 32'h104);
                    chk("new win credits", 32'(credits_o), 4);
                end
                20: begin
                    chk("win2 count", 32'(n_out), 8);
                    chk("win2 stall", 32'(stall_o), 1);
                end
                32: chk("win3 beat", 32'({valid_o, payload_o}), 32'h108);
                34: begin
                    chk("drain count", 32'(n_out), 10);
                    chk("drain stall", 32'(stall_o), 0);
                    chk("drain credits", 32'(credits_o), 2);
                end
                45: chk("pre refill credits", 32'(credits_o), 2);
                47: begin
                    chk("last cyc beat", 32'({valid_o, payload_o}), 32'h1A1);
                    chk("last cyc credits", 32'(credits_o), 1);
                end
                48: chk("refill collision credits", 32'(credits_o), 4);
                52, 54: begin
                    chk($sformatf("bp ready_o c%0d", c), 32'(ready_o), 0);
                    chk($sformatf("bp head c%0d", c), 32'({valid_o, payload_o}), 32'h1B0);
                    chk($sformatf("bp credits c%0d", c), 32'(credits_o), 4);
                end
                56: chk("bp second", 32'({valid_o, payload_o}), 32'h1B1);
                57: begin
                    chk("bp drained valid_o", 32'(valid_o), 0);
                    chk("bp credits after", 32'(credits_o), 2);
                end
                67: chk("pre rst head", 32'({valid_o, payload_o}), 32'h1C0);
                68: q1.delete();
                69: begin
                    chk("post rst valid_o", 32'(valid_o), 0);
                    chk("post rst ready_o", 32'(ready_o), 1);
                    chk("post rst credits", 32'(credits_o), 4);
                    chk("post rst stall", 32'(stall_o), 0);
                end
                84: chk("restart win credits", 32'(credits_o), 3);
                85: chk("restart refill credits", 32'(credits_o), 4);
                default: ;
            endcase
            hs_in = valid_i && ready_o;
            if (hs_in) begin
                q1.push_back(payload_i);
                n_in++;
            end
            if (valid_o && ready_i) n_out++;
            @(posedge clk); #1;
        end
        chk("total out", 32'(n_out), 15);
        chk("sb1 drained", 32'(q1.size()), 0);

        // Full throughput: MaxBeats == WindowCycles == 8.
        for (int d = 0; d < 68; d++) begin
            rst2     = 1'b0;
            ready2   = 1'b1;
            valid2   = (d < 64);
            payload2 = pl_t'(d);
            @(negedge clk);
            if (d >= 1 && d <= 64) begin
                chk($sformatf("ft beat d%0d", d), 32'({valid2_o, payload2_o}), 32'h100 + 32'(d - 1));
            end
            if (d == 65) chk("ft idle valid", 32'(valid2_o), 0);
            if (d == 7) chk("ft credits d7", 32'(credits2_o), 2);
            if (d == 8) chk("ft credits d8", 32'(credits2_o), 8);
            if (stall2_o) stall_seen++;
            if (valid2 && ready2_o) q2.push_back(payload2);
            @(posedge clk); #1;
        end
        chk("ft stall never", 32'(stall_seen), 0);
        chk("sb2 drained", 32'(q2.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
